scalar_wb_arbiter: RTL and testbench

SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

---
 rtl/scalar_wb_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_scalar_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : scalar_wb_arbiter
//  Purpose  : Round-robin arbiter for the scalar register-file write port.
//             It also tracks outstanding destination registers in a pending
//             bitmap and reports RAW/WAW hazards to the issue stage.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH     register word width (default `DATA_WIDTH, 32)
//    NUM_SRC        number of writeback requesters
//                   (0 = ALU, 1 = LSU, 2 = VECTOR_TO_SCALAR)
//  Ports
//    clk            single clock
//    reset          asynchronous, active-low reset
//    src_valid      per-source write request
//    src_ready      one-hot combinational grant
//    src_rd         per-source destination index, 5 bits each
//    src_data       per-source write data, DATA_WIDTH bits each
//    wb_we          write strobe to the scalar register file (registered)
//    wb_rd          write index (registered)
//    wb_data        write data (registered)
//    mask_write     pulses with wb_we when register 31 (exec mask) is written
//    issue_valid    instruction issuing this cycle
//    issue_rd       destination of the issuing instruction
//    issue_ready    no WAW hazard on issue_rd
//    rs1_addr       source operand 1 index
//    rs2_addr       source operand 2 index
//    hazard_rs1     rs1 has an outstanding write
//    hazard_rs2     rs2 has an outstanding write
//    flush          warp flush: clear bitmap and round-robin pointer
//    pending_count  number of outstanding writes (registered)
//  Build option
//    SCALAR_WB_BYPASS_EN  when defined, a register cleared by this cycle's
//                         grant is already visible as free to issue_ready
//                         and hazard_rsN in the same cycle.
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module scalar_wb_arbiter #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int NUM_SRC    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*5-1:0]          src_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          wb_we,
    output logic [4:0]                    wb_rd,
    output logic [DATA_WIDTH-1:0]         wb_data,
    output logic                          mask_write,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic                          issue_ready,
    input  logic [4:0]                    rs1_addr,
    input  logic [4:0]                    rs2_addr,
    output logic                          hazard_rs1,
    output logic                          hazard_rs2,
    input  logic                          flush,
    output logic [5:0]                    pending_count
);

    localparam int c_PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [4:0] c_MASK_REG = 5'd31;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // The pointer is always below NUM_SRC and the offset is below NUM_SRC,
    // so a single conditional subtraction implements the modulo.
    function automatic logic [c_PTR_W-1:0] f_wrap(input int val);
        if (val >= NUM_SRC) begin
            return c_PTR_W'(val - NUM_SRC);
        end
        return c_PTR_W'(val);
    endfunction

    function automatic logic [5:0] f_popcount(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int b = 0; b < 32; b++) begin
            cnt = cnt + {5'd0, vec[b]};
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic [31:0]           r_pending;
    logic [5:0]            r_pending_count;
    logic                  r_wb_we;
    logic [4:0]            r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_mask_write;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                  w_grant_vld;
    logic [c_PTR_W-1:0]    w_grant_idx;
    logic [NUM_SRC-1:0]    w_grant_oh;
    logic [4:0]            w_grant_rd;
    logic [DATA_WIDTH-1:0] w_grant_data;
    logic                  w_wr_en;
    logic [31:0]           w_clr_mask;
    logic [31:0]           w_set_mask;
    logic [31:0]           w_pend_view;
    logic [31:0]           w_pend_nxt;
    logic [c_PTR_W-1:0]    w_rr_ptr_nxt;
    logic                  w_issue_ready;

    // ------------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr. Grants are suppressed while
    // reset is held low so nothing is accepted that would then be dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_grant_vld && reset && src_valid[f_wrap(int'(r_rr_ptr) + i)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = f_wrap(int'(r_rr_ptr) + i);
            end
        end
    end

    // Decode the winning index into the one-hot grant and mux its payload.
    always_comb begin
        w_grant_oh   = '0;
        w_grant_rd   = 5'd0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant_idx == c_PTR_W'(i)) begin
                w_grant_oh[i] = w_grant_vld;
                w_grant_rd    = src_rd[i*5 +: 5];
                w_grant_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Writes to x0 are consumed (granted) but never reach the register file.
    assign w_wr_en = w_grant_vld && (w_grant_rd != 5'd0);

    // Only a bit that is actually pending is cleared; a stray write to a
    // non-pending register leaves the bitmap alone.
    assign w_clr_mask = w_wr_en ? ((32'd1 << w_grant_rd) & r_pending) : 32'd0;

    // ------------------------------------------------------------------------
    // Hazard view of the bitmap
    // ------------------------------------------------------------------------
`ifdef SCALAR_WB_BYPASS_EN
    // Same-cycle bypass: the register being written this cycle is free now.
    assign w_pend_view = r_pending & ~w_clr_mask;
`else
    // No bypass: the cleared register becomes usable one cycle later.
    assign w_pend_view = r_pending;
`endif

    assign w_issue_ready = (issue_rd == 5'd0) || !w_pend_view[issue_rd];
    assign hazard_rs1    = (rs1_addr != 5'd0) && w_pend_view[rs1_addr];
    assign hazard_rs2    = (rs2_addr != 5'd0) && w_pend_view[rs2_addr];

    // An issue blocked by issue_ready low is simply ignored.
    assign w_set_mask = (issue_valid && w_issue_ready && (issue_rd != 5'd0))
                        ? (32'd1 << issue_rd) : 32'd0;

    // Set is OR-ed in after the clear so a simultaneous issue to the register
    // being cleared keeps it pending. Flush wins over everything.
    assign w_pend_nxt = flush ? 32'd0 : ((r_pending & ~w_clr_mask) | w_set_mask);

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (flush) begin
            w_rr_ptr_nxt = '0;
        end else if (w_grant_vld) begin
            w_rr_ptr_nxt = f_wrap(int'(w_grant_idx) + 1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr        <= '0;
            r_pending       <= 32'd0;
            r_pending_count <= 6'd0;
        end else begin
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_pending       <= w_pend_nxt;
            // Counting the next bitmap keeps the count aligned with r_pending.
            r_pending_count <= f_popcount(w_pend_nxt);
        end
    end

    // Writeback stage: one cycle after the grant. Index and data hold their
    // last granted value; only the strobes return to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_we      <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= '0;
            r_mask_write <= 1'b0;
        end else begin
            r_wb_we      <= w_wr_en;
            r_mask_write <= w_wr_en && (w_grant_rd == c_MASK_REG);
            if (w_grant_vld) begin
                r_wb_rd   <= w_grant_rd;
                r_wb_data <= w_grant_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign src_ready     = w_grant_oh;
    assign issue_ready   = w_issue_ready;
    assign wb_we         = r_wb_we;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign mask_write    = r_mask_write;
    assign pending_count = r_pending_count;

endmodule

`default_nettype wire

// File: tb/tb_scalar_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scalar_wb_arbiter
//  Purpose  : Self-checking bench for scalar_wb_arbiter. A table of per-cycle
//             input/expected-output records followed by a hand-written
//             mid-stream reset sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scalar_wb_arbiter;

`ifdef SCALAR_WB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    localparam int c_NV = 26;

    logic        clk;
    logic        reset;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mask_write;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        flush;
    logic [5:0]  pending_count;

    int r_checks;
    int r_failures;

    scalar_wb_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_rd        (src_rd),
        .src_data      (src_data),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mask_write    (mask_write),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .hazard_rs1    (hazard_rs1),
        .hazard_rs2    (hazard_rs2),
        .flush         (flush),
        .pending_count (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] d;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        fl;
        logic [2:0]  e_rdy;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        logic        e_mw;
        logic        e_ir;
        logic        e_h1;
        logic        e_h2;
        logic [5:0]  e_pc;
    } vec_t;

    vec_t vecs [c_NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_failures++;
            $display("FAIL %s actual=%h required=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {13'd0, src_ready, wb_we, wb_rd, wb_data, mask_write,
                issue_ready, hazard_rs1, hazard_rs2, pending_count};
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t t);
        return {13'd0, t.e_rdy, t.e_we, t.e_rd, t.e_d, t.e_mw,
                t.e_ir, t.e_h1, t.e_h2, t.e_pc};
    endfunction

    initial begin
        logic [14:0] c_ra;
        logic [95:0] c_da;
        logic [14:0] c_r0;
        logic [95:0] c_d0;
        c_ra = {5'd3, 5'd2, 5'd1};
        c_da = {32'h33, 32'h22, 32'h11};
        c_r0 = 15'd0;
        c_d0 = 96'd0;

        //           v  rd    data  iv ird  rs1  rs2  fl   rdy we rd  data        mw ir h1 h2 pc
        vecs[0]  = '{0, c_r0, c_d0, 0, 0,   0,   0,   0,   0, 0, 0,  32'h0,       0, 1, 0, 0, 0};
        // all three valid: 0,1,2,0,1,2
        vecs[1]  = '{7, c_ra, c_da, 0, 0,   0,   0,   0,   1, 0, 0,  32'h0,       0, 1, 0, 0, 0};
        vecs[2]  = '{7, c_ra, c_da, 0, 0,   0,   0,   0,   2, 1, 1,  32'h11,      0, 1, 0, 0, 0};
        vecs[3]  = '{7, c_ra, c_da, 0, 0,   0,   0,   0,   4, 1, 2,  32'h22,      0, 1, 0, 0, 0};
        vecs[4]  = '{7, c_ra, c_da, 0, 0,   0,   0,   0,   1, 1, 3,  32'h33,      0, 1, 0, 0, 0};
        vecs[5]  = '{7, c_ra, c_da, 0, 0,   0,   0,   0,   2, 1, 1,  32'h11,      0, 1, 0, 0, 0};
        vecs[6]  = '{7, c_ra, c_da, 0, 0,   0,   0,   0,   4, 1, 2,  32'h22,      0, 1, 0, 0, 0};
        vecs[7]  = '{0, c_ra, c_da, 0, 0,   0,   0,   0,   0, 1, 3,  32'h33,      0, 1, 0, 0, 0};
        vecs[8]  = '{0, c_ra, c_da, 0, 0,   0,   0,   0,   0, 0, 3,  32'h33,      0, 1, 0, 0, 0};
        // pointer held at 0, then wrap-around search from 2 to 0
        vecs[9]  = '{6, c_ra, c_da, 0, 0,   0,   0,   0,   2, 0, 3,  32'h33,      0, 1, 0, 0, 0};
        vecs[10] = '{3, c_ra, c_da, 0, 0,   0,   0,   0,   1, 1, 2,  32'h22,      0, 1, 0, 0, 0};
        vecs[11] = '{0, c_ra, c_da, 0, 0,   0,   0,   0,   0, 1, 1,  32'h11,      0, 1, 0, 0, 0};
        // issue rd 5, LSU writes rd 5
        vecs[12] = '{0, c_r0, c_d0, 1, 5,   5,   0,   0,   0, 0, 1,  32'h11,      0, 1, 0, 0, 0};
        vecs[13] = '{2, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                        0, 5,   5,   0,   0,   2, 0, 1,  32'h11,      0, c_BYP, !c_BYP, 0, 1};
        vecs[14] = '{0, c_r0, c_d0, 0, 5,   5,   0,   0,   0, 1, 5,  32'hDEADBEEF, 0, 1, 0, 0, 0};
        // issue rd 7 twice, ALU writes rd 0
        vecs[15] = '{0, c_r0, c_d0, 1, 7,   0,   0,   0,   0, 0, 5,  32'hDEADBEEF, 0, 1, 0, 0, 0};
        vecs[16] = '{1, c_r0, {64'h0, 32'h55},
                        1, 7,   0,   7,   0,   1, 0, 5,  32'hDEADBEEF, 0, 0, 0, 1, 1};
        vecs[17] = '{0, c_r0, c_d0, 0, 7,   0,   7,   0,   0, 0, 0,  32'h55,      0, 0, 0, 1, 1};
        // V2S writes the mask register
        vecs[18] = '{4, {5'd31, 5'd0, 5'd0}, {32'hF, 64'h0},
                        0, 0,   0,   7,   0,   4, 0, 0,  32'h55,      0, 1, 0, 1, 1};
        vecs[19] = '{0, c_r0, c_d0, 0, 0,   0,   0,   0,   0, 1, 31, 32'hF,       1, 1, 0, 0, 1};
        // pend 3 and 9, then flush with issue rd 12 and a grant to rd 9
        vecs[20] = '{0, c_r0, c_d0, 1, 3,   0,   0,   0,   0, 0, 31, 32'hF,       0, 1, 0, 0, 1};
        vecs[21] = '{0, c_r0, c_d0, 1, 9,   0,   0,   0,   0, 0, 31, 32'hF,       0, 1, 0, 0, 2};
        vecs[22] = '{2, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h99, 32'h0},
                        1, 12,  3,   9,   1,   2, 0, 31, 32'hF,       0, 1, 1, !c_BYP, 3};
        vecs[23] = '{0, c_r0, c_d0, 0, 12,  3,   9,   0,   0, 1, 9,  32'h99,      0, 1, 0, 0, 0};
        vecs[24] = '{0, c_r0, c_d0, 0, 0,   12,  3,   0,   0, 0, 9,  32'h99,      0, 1, 0, 0, 0};
        // flush returned the pointer to 0
        vecs[25] = '{7, c_ra, c_da, 0, 0,   0,   0,   0,   1, 0, 9,  32'h99,      0, 1, 0, 0, 0};

        r_checks    = 0;
        r_failures  = 0;
        reset       = 1'b0;
        src_valid   = '0;
        src_rd      = '0;
        src_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        flush       = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {58'd0, wb_we, mask_write, src_ready, 1'b0},
              64'd0);
        check("reset_count", {58'd0, pending_count}, 64'd0);
        reset = 1'b1;

        for (int k = 0; k < c_NV; k++) begin
            @(negedge clk);
            src_valid   = vecs[k].v;
            src_rd      = vecs[k].rd;
            src_data    = vecs[k].d;
            issue_valid = vecs[k].iv;
            issue_rd    = vecs[k].ird;
            rs1_addr    = vecs[k].rs1;
            rs2_addr    = vecs[k].rs2;
            flush       = vecs[k].fl;
            #1;
            check($sformatf("vec%0d", k), pack_out(), pack_exp(vecs[k]));
        end

        // Mid-stream asynchronous reset with a write in flight.
        @(negedge clk);
        src_valid   = 3'b111;
        src_rd      = c_ra;
        src_data    = c_da;
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        flush       = 1'b0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        #1;
        check("pre_rst_grant", {51'd0, src_ready, wb_we, wb_rd, 4'd0},
              {51'd0, 3'b010, 1'b1, 5'd1, 4'd0});
        @(negedge clk);
        issue_valid = 1'b0;
        rs1_addr    = 5'd4;
        #1;
        check("pre_rst_state", {24'd0, wb_we, wb_rd, wb_data, hazard_rs1, pending_count},
              {24'd0, 1'b1, 5'd2, 32'h22, 1'b1, 6'd1});
        reset = 1'b0;
        #1;
        check("async_rst_outs", {24'd0, wb_we, wb_rd, wb_data, mask_write, pending_count},
              64'd0);
        check("async_rst_nogrant", {60'd0, src_ready, hazard_rs1}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held", {58'd0, wb_we, src_ready, pending_count[1:0]}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_grant", {61'd0, src_ready}, 64'd1);
        @(posedge clk);
        #1;
        check("post_rst_wb", {26'd0, wb_we, wb_rd, wb_data}, {26'd0, 1'b1, 5'd1, 32'h11});

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
